lutram_fifo: RTL

Synchronous FIFO built around a single `lutram_1w_1r` instance: it owns the write and read pointers, occupancy count and full/empty flags, and drives the LUTRAM's `waddr`, `raddr`, `ram_write` and `new_ram_data`. It sits directly upstream of the distributed RAM and serves as the standard small inter-stage buffer in the core, for example between the fetch and decode stages or in front of unit issue queues. Read data is available in the same cycle as `valid`, using the LUTRAM's asynchronous read port.

---
 rtl/lutram_fifo.sv | 90 +++++++++
 1 files changed

// File: rtl/lutram_fifo.sv
// Synchronous FIFO over a single distributed RAM with an asynchronous read port.
// Optional macro LUTRAM_FIFO_OVERFLOW_CHECK_EN adds a sticky protocol-violation flag (err).

module lutram_1w_1r #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  input  logic                     ram_write,
  input  logic [WIDTH-1:0]         new_ram_data,
  output logic [WIDTH-1:0]         ram_data_out
);
  logic [WIDTH-1:0] ram [DEPTH];

  always_ff @(posedge clk) begin
    if (ram_write) ram[waddr] <= new_ram_data;
  end

  assign ram_data_out = ram[raddr];
endmodule

// Handshake: push is taken when the FIFO is not full or a pop is accepted in
// the same cycle; pop is taken only while valid. Untaken requests are dropped.
module lutram_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          pop,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          valid,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          err
);
  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [ADDR_W-1:0] write_index;
  logic [ADDR_W-1:0] read_index;
  logic              push_accepted;
  logic              pop_accepted;

  assign valid = (count != '0);
  assign full  = (count == CNT_W'(FIFO_DEPTH));

  assign push_accepted = push & (~full | pop);
  assign pop_accepted  = pop & valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      write_index <= '0;
      read_index  <= '0;
      count       <= '0;
    end else begin
      write_index <= write_index + ADDR_W'(push_accepted);
      read_index  <= read_index + ADDR_W'(pop_accepted);
      count       <= count + CNT_W'(push_accepted) - CNT_W'(pop_accepted);
    end
  end

  lutram_1w_1r #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_ram (
    .clk          (clk),
    .waddr        (write_index),
    .raddr        (read_index),
    .ram_write    (push_accepted),
    .new_ram_data (data_in),
    .ram_data_out (data_out)
  );

`ifdef LUTRAM_FIFO_OVERFLOW_CHECK_EN
  logic violation;
  assign violation = (push & full & ~pop) | (pop & ~valid);

  always_ff @(posedge clk) begin
    if (rst)            err <= 1'b0;
    else if (violation) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif
endmodule
